// File: rtl/pipe_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_if
//   valid/ready/data handshake bundle used on both sides of a PIPE stage.
//
//   Parameters:
//     WIDTH  payload width in bits
//
//   Signals:
//     valid  producer has a payload this cycle
//     ready  consumer can accept this cycle
//     data   payload, meaningful only while valid=1
//
//   Modports:
//     master  producer side: drives valid/data, observes ready
//     slave   consumer side: drives ready, observes valid/data
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Handshaked PIPE stage register with a 2-entry skid buffer. The upstream
//   ready is driven straight from a flop, so the combinational ready path
//   between neighbouring stages is broken. A synchronous flush drops every
//   held entry for exception / mispredict recovery.
//
//   Parameters:
//     WIDTH           payload width in bits (>=1)
//     CLEAR_ON_FLUSH  1: payload registers zeroed on flush, 0: left stale
//     CNT_W           statistics counter width (stats build only)
//
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous, active-low reset
//     flush      synchronous kill of all held entries
//     up         slave side: in_valid / in_ready (registered) / in_data
//     dn         master side: out_valid / out_ready / out_data (registered)
//     occupancy  entries held: 0, 1 or 2 (registered)
//     stall_cnt  cycles with out_valid=1 & out_ready=0, saturating
//     flush_cnt  flushes that hit a non-empty stage, saturating
//
//   Build option:
//     PIPE_SKID_STATS_EN  when defined, adds stall_cnt / flush_cnt ports and
//                         their counters; otherwise they are absent.
//
//   state  | meaning
//   -------+----------------------------------------------
//   EMPTY  | main and skid invalid, in_ready=1
//   BUSY   | main valid, skid invalid, in_ready=1
//   FULL   | main and skid valid, in_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int WIDTH          = 64,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  pipe_stage_skid_if.slave        up,
  pipe_stage_skid_if.master       dn,
`ifdef PIPE_SKID_STATS_EN
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt,
`endif
  output logic [1:0]              occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [1:0]       occ_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = up.valid & in_ready_q;
  assign out_fire = out_valid_q & dn.ready;

  assign up.ready  = in_ready_q;
  assign dn.valid  = out_valid_q;
  assign dn.data   = main_data;
  assign occupancy = occ_q;

  // All visible outputs are registered alongside the state so that in_ready
  // never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_EMPTY;
      main_data   <= '0;
      skid_data   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else if (flush) begin
      // Any input fire this cycle is dropped; an output fire has already
      // been taken by downstream, which handles its own flush.
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
      if (CLEAR_ON_FLUSH) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state       <= ST_BUSY;
            main_data   <= up.data;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd1;
          end
        end

        ST_BUSY: begin
          if (in_fire && !out_fire) begin
            // Downstream stalled: park the new beat in the skid entry.
            state      <= ST_FULL;
            skid_data  <= up.data;
            in_ready_q <= 1'b0;
            occ_q      <= 2'd2;
          end else if (in_fire && out_fire) begin
            main_data <= up.data;
          end else if (out_fire) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            state      <= ST_BUSY;
            main_data  <= skid_data;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd1;
          end
        end

        default: begin
          state       <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid_q && !dn.ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush && (occ_q != 2'd0) && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int W     = 32;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;
`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  pipe_stage_skid_if #(.WIDTH(W)) up_if ();
  pipe_stage_skid_if #(.WIDTH(W)) dn_if ();

  pipe_stage_skid #(
    .WIDTH          (W),
    .CLEAR_ON_FLUSH (1'b1),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
`ifdef PIPE_SKID_STATS_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the next negedge. The model is the queue
  // of payloads the stage should currently hold, oldest first.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    logic rdy0;
    bit   m_rdy;
    bit   m_vld;
    rdy0  = up_if.ready;
    m_rdy = (exp_q.size() < 2);
    m_vld = (exp_q.size() != 0);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = r;
    flush       = f;
    #1;
    chk("in_ready_comb", 64'(up_if.ready), 64'(rdy0));
    #3;
    if (m_vld && r) chk("out_data", 64'(dn_if.data), 64'(exp_q.pop_front()));
    if (f) exp_q.delete();
    else if (v && m_rdy) exp_q.push_back(d);
    @(negedge clk);
    chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
    chk("in_ready", 64'(up_if.ready), 64'(exp_q.size() < 2));
    chk("out_valid", 64'(dn_if.valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_hold", 64'(dn_if.data), 64'(exp_q[0]));
  endtask

  initial begin
    rst         = 1'b0;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(dn_if.valid), 64'd0);
    chk("rst_out_data", 64'(dn_if.data), 64'd0);
    chk("rst_in_ready", 64'(up_if.ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    rst = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure fill then drain.
    cycle(1'b1, W'('h11), 1'b0, 1'b0);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    cycle(1'b1, W'('h22), 1'b0, 1'b0);
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(up_if.ready), 64'd0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // out_ready toggling every cycle.
    for (int i = 0; i < 30; i++) cycle(1'b1, W'(100 + i), (i % 2) == 0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush in FULL with a concurrent input that must be discarded.
    cycle(1'b1, W'('hA1), 1'b0, 1'b0);
    cycle(1'b1, W'('hA2), 1'b0, 1'b0);
    cycle(1'b1, W'('h33), 1'b0, 1'b1);
    chk("flush_out_data", 64'(dn_if.data), 64'd0);
    chk("flush_out_valid", 64'(dn_if.valid), 64'd0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL.
    cycle(1'b1, W'('hB1), 1'b0, 1'b0);
    cycle(1'b1, W'('hB2), 1'b0, 1'b0);
    chk("pre_arst_occ", 64'(occupancy), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(dn_if.valid), 64'd0);
    chk("arst_in_ready", 64'(up_if.ready), 64'd1);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_SKID_STATS_EN
    rst = 1'b0;
    @(negedge clk);
    chk("stats_rst_stall", 64'(stall_cnt), 64'd0);
    chk("stats_rst_flush", 64'(flush_cnt), 64'd0);
    rst = 1'b1;
    cycle(1'b1, W'('hC1), 1'b0, 1'b0);
    repeat (20) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("stall_cnt_sat", 64'(stall_cnt), 64'd15);
    cycle(1'b1, W'('hC2), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("flush_cnt", 64'(flush_cnt), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline-stage register for the PIPE hierarchy; successor to the fixed-field stall/flush stage registers.
- Carries an opaque WIDTH-bit payload with valid/ready flow control instead of a global stall.
- A 2-entry skid buffer keeps in_ready registered, breaking the combinational ready path between stages.
- Synchronous flush kills in-flight entries, for exception and mispredict recovery.

Parameters:
- WIDTH, 64, payload width in bits (>=1).
- CLEAR_ON_FLUSH, 1, 1: payload registers zeroed on flush; 0: payload left stale, only valids cleared.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream has payload.
- in_ready  output  1  stage can accept; registered.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  main entry holds payload.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  main entry payload; registered.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_cnt  output  CNT_W  only with PIPE_SKID_STATS_EN.
- flush_cnt  output  CNT_W  only with PIPE_SKID_STATS_EN.

Behaviour:
- Reset (rst=0, asynchronous): state EMPTY; out_valid=0; out_data=0; skid data=0; in_ready=1; occupancy=0; counters=0.
- Handshakes:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - in_data is sampled only on input fire.
  - in_valid may drop without a transfer.
- States:
  - EMPTY: main and skid invalid.
  - BUSY: main valid.
  - FULL: main and skid valid.
- Transitions (flush=0):
  - EMPTY + in fire -> BUSY; main<=in_data.
  - BUSY + in fire, no out fire -> FULL; skid<=in_data.
  - BUSY + in fire + out fire -> BUSY; main<=in_data.
  - BUSY + out fire, no in fire -> EMPTY.
  - FULL + out fire -> BUSY; main<=skid.
  - FULL holds otherwise.
  - Input fire in FULL is impossible, since in_ready=0.
- Outputs and latency:
  - in_ready = (state != FULL), taken from a flop, never from out_ready.
  - Latency is 1 cycle from input fire to out_valid.
  - Sustained throughput is 1 per cycle when out_ready=1.
- Ordering: payloads leave strictly in arrival order; none duplicated or dropped unless flushed.
- Stability: while out_valid=1 and out_ready=0, out_data is held stable.
- Flush:
  - flush=1 at an edge forces state EMPTY regardless of in/out activity.
  - An input fire in the flush cycle is discarded.
  - An output fire in the flush cycle still counts as consumed downstream (downstream owns its own flush).
  - Next cycle: out_valid=0, in_ready=1, occupancy=0.
  - CLEAR_ON_FLUSH=1 zeroes main and skid payloads; CLEAR_ON_FLUSH=0 leaves them unchanged.
- Simultaneous flush and rst=0: reset dominates.
- Reset asserted mid-transfer: all entries lost, immediately and asynchronously.
- occupancy: 0 in EMPTY, 1 in BUSY, 2 in FULL; registered.

Optional Feature:
- Macro: PIPE_SKID_STATS_EN.
- Defined:
  - stall_cnt increments each cycle out_valid=1 & out_ready=0.
  - flush_cnt increments each cycle flush=1 with occupancy!=0.
  - Both saturate at all-ones; both reset to 0 by rst.
- Undefined: both ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset then stream: rst low 3 cycles, then in_valid=1 with data 1..8, out_ready=1. Required: in_ready=1 throughout; out_data=1..8 on consecutive cycles, one cycle after each input; occupancy=1.
- Backpressure fill: out_ready=0, push A=0x11, B=0x22. Required: occupancy 1 then 2; in_ready=0 after B. Then out_ready=1: outputs 0x11 then 0x22; in_ready=1 the cycle after 0x11 leaves.
- Ready decoupling: toggle out_ready every cycle with in_valid=1 and incrementing data. Required: no loss or duplication; in_ready never changes in the same cycle as out_ready.
- Flush in FULL with a concurrent input C=0x33, CLEAR_ON_FLUSH=1. Required next cycle: out_valid=0, out_data=0, occupancy=0, in_ready=1; C never appears.
- Async reset mid-stream: drop rst between edges while in FULL. Required: out_valid=0 and in_ready=1 immediately, before the next clock edge.
- Stats (PIPE_SKID_STATS_EN, CNT_W=4): hold out_ready=0 with out_valid=1 for 20 cycles. Required: stall_cnt=15 (saturated). One flush with occupancy=2: flush_cnt=1.
